// File: rtl/cpu_video_timing_pkg.sv
// Video/CPU timing constants shared with the video and sound blocks,
// plus the CPU phase state encoding and a half-open range decode helper.
package timing_pkg;

   localparam int unsigned H_TOTAL_DEF      = 320;
   localparam int unsigned V_TOTAL_DEF      = 256;
   localparam int unsigned HBLANK_START_DEF = 256;
   localparam int unsigned HSYNC_START_DEF  = 272;
   localparam int unsigned HSYNC_END_DEF    = 304;
   localparam int unsigned VBLANK_START_DEF = 231;
   localparam int unsigned VSYNC_START_DEF  = 240;
   localparam int unsigned VSYNC_END_DEF    = 243;
   localparam int unsigned EXT_CYCLES_DEF   = 4;

   // One-hot encoding so a corrupted state register is caught by the default arm.
   typedef enum logic [1:0] {
      PH_RUN    = 2'b01,
      PH_EXTEND = 2'b10
   } phase_state_e;

   function automatic logic in_window(input logic [8:0] val,
                                      input logic [8:0] lo,
                                      input logic [8:0] hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/cpu_video_timing_if.sv
// Timing generator outputs and the slow-access stretch request.
interface cpu_video_timing_if;
   logic       slow_req;
   logic       pix_ce;
   logic [8:0] hcnt;
   logic [7:0] vcnt;
   logic       hsync_n;
   logic       vsync_n;
   logic       hblank;
   logic       vblank;
   logic       s_phi_x;
   logic       s_phi_extend;
   logic       frame_start;

   modport master (
      input  slow_req,
      output pix_ce, hcnt, vcnt, hsync_n, vsync_n, hblank, vblank,
             s_phi_x, s_phi_extend, frame_start
   );

   modport slave (
      output slow_req,
      input  pix_ce, hcnt, vcnt, hsync_n, vsync_n, hblank, vblank,
             s_phi_x, s_phi_extend, frame_start
   );
endinterface

// File: rtl/cpu_video_timing_cpu_phase_gen.sv
// CPU phase generator: 8-clock phi cycle whose high phase is stretched by
// EXT_CYCLES clocks when slow_req is seen at the end of a high phase.
module cpu_phase_gen
   import timing_pkg::*;
#(
   parameter int unsigned EXT_CYCLES = EXT_CYCLES_DEF
) (
   input  logic clk_10M,
   input  logic reset,
   input  logic slow_req,
   output logic s_phi_x,
   output logic s_phi_extend
);

   localparam logic [3:0] L_EXT_LOAD = 4'(EXT_CYCLES - 1);

   phase_state_e r_state;
   logic [2:0]   r_cpu_cnt;
   logic [3:0]   r_ext_cnt;
   logic         r_phi_x;
   logic         r_phi_extend;
   logic [2:0]   w_cnt_inc;

   assign w_cnt_inc    = r_cpu_cnt + 3'd1;
   assign s_phi_x      = r_phi_x;
   assign s_phi_extend = r_phi_extend;

   // Phase counter and RUN/EXTEND stretch FSM; phi follows the next count's MSB.
   always_ff @(posedge clk_10M) begin
      if (reset) begin
         r_state      <= PH_RUN;
         r_cpu_cnt    <= 3'd0;
         r_ext_cnt    <= 4'd0;
         r_phi_x      <= 1'b0;
         r_phi_extend <= 1'b0;
      end else begin
         case (r_state)
            PH_RUN: begin
               if ((r_cpu_cnt == 3'd7) && slow_req) begin
                  r_state      <= PH_EXTEND;
                  r_ext_cnt    <= L_EXT_LOAD;
                  r_phi_x      <= 1'b1;
                  r_phi_extend <= 1'b1;
               end else begin
                  r_cpu_cnt    <= w_cnt_inc;
                  r_phi_x      <= w_cnt_inc[2];
                  r_phi_extend <= 1'b0;
               end
            end
            PH_EXTEND: begin
               if (r_ext_cnt != 4'd0) begin
                  r_ext_cnt <= r_ext_cnt - 4'd1;
               end else begin
                  r_state      <= PH_RUN;
                  r_cpu_cnt    <= 3'd0;
                  r_phi_x      <= 1'b0;
                  r_phi_extend <= 1'b0;
               end
            end
            default: begin
               r_state      <= PH_RUN;
               r_cpu_cnt    <= 3'd0;
               r_ext_cnt    <= 4'd0;
               r_phi_x      <= 1'b0;
               r_phi_extend <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/cpu_video_timing.sv
// Master timing generator: pixel enable, video counters with sync/blank
// decode, and the CPU phase pair from cpu_phase_gen.
module cpu_video_timing
   import timing_pkg::*;
#(
   parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
   parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
   parameter int unsigned HBLANK_START = HBLANK_START_DEF,
   parameter int unsigned HSYNC_START  = HSYNC_START_DEF,
   parameter int unsigned HSYNC_END    = HSYNC_END_DEF,
   parameter int unsigned VBLANK_START = VBLANK_START_DEF,
   parameter int unsigned VSYNC_START  = VSYNC_START_DEF,
   parameter int unsigned VSYNC_END    = VSYNC_END_DEF,
   parameter int unsigned EXT_CYCLES   = EXT_CYCLES_DEF
) (
   input  logic               clk_10M,
   input  logic               reset,
   cpu_video_timing_if.master vt
);

   localparam logic [8:0] L_H_LAST       = 9'(H_TOTAL - 1);
   localparam logic [7:0] L_V_LAST       = 8'(V_TOTAL - 1);
   localparam logic [8:0] L_H_TOTAL      = 9'(H_TOTAL);
   localparam logic [8:0] L_V_TOTAL      = 9'(V_TOTAL);
   localparam logic [8:0] L_HBLANK_START = 9'(HBLANK_START);
   localparam logic [8:0] L_HSYNC_START  = 9'(HSYNC_START);
   localparam logic [8:0] L_HSYNC_END    = 9'(HSYNC_END);
   localparam logic [8:0] L_VBLANK_START = 9'(VBLANK_START);
   localparam logic [8:0] L_VSYNC_START  = 9'(VSYNC_START);
   localparam logic [8:0] L_VSYNC_END    = 9'(VSYNC_END);

   logic       r_pixdiv;
   logic       r_pix_ce;
   logic [8:0] r_hcnt;
   logic [7:0] r_vcnt;
   logic       r_hsync_n;
   logic       r_vsync_n;
   logic       r_hblank;
   logic       r_vblank;
   logic       r_frame_start;
   logic       w_line_end;
   logic       w_frame_end;
   logic [8:0] w_hcnt_nxt;
   logic [7:0] w_vcnt_nxt;

   // Next-state counter values; decodes are taken from these so they line up.
   always_comb begin
      w_line_end  = r_pix_ce && (r_hcnt == L_H_LAST);
      w_frame_end = w_line_end && (r_vcnt == L_V_LAST);
      w_hcnt_nxt  = r_hcnt;
      w_vcnt_nxt  = r_vcnt;
      if (w_line_end) begin
         w_hcnt_nxt = 9'd0;
         if (w_frame_end) begin
            w_vcnt_nxt = 8'd0;
         end else begin
            w_vcnt_nxt = r_vcnt + 8'd1;
         end
      end else if (r_pix_ce) begin
         w_hcnt_nxt = r_hcnt + 9'd1;
      end else begin
         w_hcnt_nxt = r_hcnt;
      end
   end

   // Pixel divider, video counters and registered sync/blank decode.
   always_ff @(posedge clk_10M) begin
      if (reset) begin
         r_pixdiv      <= 1'b0;
         r_pix_ce      <= 1'b0;
         r_hcnt        <= 9'd0;
         r_vcnt        <= 8'd0;
         r_hsync_n     <= 1'b1;
         r_vsync_n     <= 1'b1;
         r_hblank      <= 1'b0;
         r_vblank      <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pixdiv      <= ~r_pixdiv;
         r_pix_ce      <= r_pixdiv;
         r_hcnt        <= w_hcnt_nxt;
         r_vcnt        <= w_vcnt_nxt;
         r_hblank      <= in_window(w_hcnt_nxt, L_HBLANK_START, L_H_TOTAL);
         r_hsync_n     <= ~in_window(w_hcnt_nxt, L_HSYNC_START, L_HSYNC_END);
         r_vblank      <= in_window({1'b0, w_vcnt_nxt}, L_VBLANK_START, L_V_TOTAL);
         r_vsync_n     <= ~in_window({1'b0, w_vcnt_nxt}, L_VSYNC_START, L_VSYNC_END);
         r_frame_start <= w_frame_end;
      end
   end

   assign vt.pix_ce      = r_pix_ce;
   assign vt.hcnt        = r_hcnt;
   assign vt.vcnt        = r_vcnt;
   assign vt.hsync_n     = r_hsync_n;
   assign vt.vsync_n     = r_vsync_n;
   assign vt.hblank      = r_hblank;
   assign vt.vblank      = r_vblank;
   assign vt.frame_start = r_frame_start;

   cpu_phase_gen #(
      .EXT_CYCLES (EXT_CYCLES)
   ) u_cpu_phase_gen (
      .clk_10M      (clk_10M),
      .reset        (reset),
      .slow_req     (vt.slow_req),
      .s_phi_x      (vt.s_phi_x),
      .s_phi_extend (vt.s_phi_extend)
   );

endmodule

// File: tb/tb_cpu_video_timing.sv
// Directed bench for cpu_video_timing; vertical timing is shortened to a
// 12-line frame so full frame wrap fits in a short run.
module tb_cpu_video_timing;

   logic clk_10M = 1'b0;
   logic reset   = 1'b1;
   int   checks  = 0;
   int   errors  = 0;
   int   low_run = 0;
   bit   mon_en  = 1'b0;

   cpu_video_timing_if vt();

   cpu_video_timing #(
      .V_TOTAL      (12),
      .VBLANK_START (7),
      .VSYNC_START  (9),
      .VSYNC_END    (10)
   ) dut (
      .clk_10M (clk_10M),
      .reset   (reset),
      .vt      (vt)
   );

   always #50 clk_10M = ~clk_10M;

   // One clock, sampled 1 time unit after the edge; tracks phi low width.
   task automatic tick();
      @(posedge clk_10M);
      #1;
      if (mon_en) begin
         if ((vt.s_phi_x | vt.s_phi_extend) == 1'b0) begin
            low_run++;
         end else begin
            if (low_run != 0) begin
               checks++;
               if (low_run < 4) begin
                  errors++;
                  $display("FAIL phi_low_width got=%0d clocks required>=4", low_run);
               end
            end
            low_run = 0;
         end
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      vt.slow_req = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   function automatic logic [22:0] video_obs();
      return {vt.pix_ce, vt.hcnt, vt.vcnt, vt.hsync_n, vt.vsync_n,
              vt.hblank, vt.vblank, vt.frame_start};
   endfunction

   // Expected video outputs k clocks after reset release (12-line frame).
   function automatic logic [22:0] video_exp(input int k);
      int   n, h, v;
      logic pce, fs;
      n   = (k >= 1) ? (k - 1) / 2 : 0;
      h   = n % 320;
      v   = (n / 320) % 12;
      pce = (k >= 2) && (k % 2 == 0);
      fs  = (k % 2 == 1) && (n > 0) && (n % 3840 == 0);
      return {pce, 9'(h), 8'(v), ~((h >= 272) && (h < 304)), ~(v == 9),
              (h >= 256), (v >= 7), fs};
   endfunction

   task automatic test_reset();
      logic [22:0] exp_v;
      reset       = 1'b1;
      vt.slow_req = 1'b0;
      repeat (3) tick();
      exp_v = video_exp(0);
      checks++;
      if (video_obs() !== exp_v) begin
         errors++;
         $display("FAIL reset_video got=%h exp=%h", video_obs(), exp_v);
      end
      checks++;
      if ({vt.s_phi_x, vt.s_phi_extend} !== 2'b00) begin
         errors++;
         $display("FAIL reset_phi got=%b exp=00", {vt.s_phi_x, vt.s_phi_extend});
      end
      mon_en = 1'b1;
   endtask

   task automatic test_frame_and_decode();
      logic [22:0] exp_v;
      logic        exp_phi;
      int          fs_count, fs_edge;
      fs_count = 0;
      fs_edge  = 0;
      do_reset();
      for (int k = 1; k <= 7700; k++) begin
         tick();
         exp_v   = video_exp(k);
         exp_phi = ((k % 8) >= 4);
         checks++;
         if (video_obs() !== exp_v) begin
            errors++;
            $display("FAIL frame_video k=%0d got=%h exp=%h", k, video_obs(), exp_v);
         end
         checks++;
         if ({vt.s_phi_x, vt.s_phi_extend} !== {exp_phi, 1'b0}) begin
            errors++;
            $display("FAIL free_phi k=%0d got=%b exp=%b", k,
                     {vt.s_phi_x, vt.s_phi_extend}, {exp_phi, 1'b0});
         end
         if (vt.frame_start === 1'b1) begin
            fs_count++;
            fs_edge = k;
         end
      end
      checks++;
      if ((fs_count !== 1) || (fs_edge !== 7681)) begin
         errors++;
         $display("FAIL frame_start_once got count=%0d at=%0d exp count=1 at=7681",
                  fs_count, fs_edge);
      end
   endtask

   task automatic test_slow_continuous();
      logic exp_phi, exp_ext;
      int   q;
      do_reset();
      vt.slow_req = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k < 4) begin
            exp_phi = 1'b0;
            exp_ext = 1'b0;
         end else begin
            q       = (k - 4) % 12;
            exp_phi = (q < 8);
            exp_ext = (q >= 4) && (q < 8);
         end
         checks++;
         if ({vt.s_phi_x, vt.s_phi_extend} !== {exp_phi, exp_ext}) begin
            errors++;
            $display("FAIL slow_cont_phi k=%0d got=%b exp=%b", k,
                     {vt.s_phi_x, vt.s_phi_extend}, {exp_phi, exp_ext});
         end
         checks++;
         if (vt.hcnt !== 9'((k - 1) / 2)) begin
            errors++;
            $display("FAIL slow_cont_hcnt k=%0d got=%0d exp=%0d", k, vt.hcnt, (k - 1) / 2);
         end
      end
      vt.slow_req = 1'b0;
   endtask

   task automatic test_slow_pulse();
      logic exp_phi, exp_ext;
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         vt.slow_req = ((k == 4) || (k == 16));
         tick();
         if (k < 16) begin
            exp_phi = ((k % 8) >= 4);
            exp_ext = 1'b0;
         end else if (k < 20) begin
            exp_phi = 1'b1;
            exp_ext = 1'b1;
         end else begin
            exp_phi = (((k - 20) % 8) >= 4);
            exp_ext = 1'b0;
         end
         checks++;
         if ({vt.s_phi_x, vt.s_phi_extend} !== {exp_phi, exp_ext}) begin
            errors++;
            $display("FAIL slow_pulse k=%0d got=%b exp=%b", k,
                     {vt.s_phi_x, vt.s_phi_extend}, {exp_phi, exp_ext});
         end
      end
      vt.slow_req = 1'b0;
   endtask

   task automatic test_reset_mid_stretch();
      logic [22:0] exp_v;
      logic        exp_phi;
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         vt.slow_req = (k == 8);
         tick();
      end
      vt.slow_req = 1'b0;
      checks++;
      if ({vt.s_phi_x, vt.s_phi_extend} !== 2'b11) begin
         errors++;
         $display("FAIL mid_stretch_pre got=%b exp=11", {vt.s_phi_x, vt.s_phi_extend});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_v = video_exp(0);
      checks++;
      if (video_obs() !== exp_v) begin
         errors++;
         $display("FAIL mid_stretch_video got=%h exp=%h", video_obs(), exp_v);
      end
      checks++;
      if ({vt.s_phi_x, vt.s_phi_extend} !== 2'b00) begin
         errors++;
         $display("FAIL mid_stretch_phi got=%b exp=00", {vt.s_phi_x, vt.s_phi_extend});
      end
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_v   = video_exp(k);
         exp_phi = ((k % 8) >= 4);
         checks++;
         if ({video_obs(), vt.s_phi_x, vt.s_phi_extend} !== {exp_v, exp_phi, 1'b0}) begin
            errors++;
            $display("FAIL mid_stretch_resume k=%0d got=%h exp=%h", k,
                     {video_obs(), vt.s_phi_x, vt.s_phi_extend}, {exp_v, exp_phi, 1'b0});
         end
      end
   endtask

   initial begin
      vt.slow_req = 1'b0;
      test_reset();
      test_frame_and_decode();
      test_slow_continuous();
      test_slow_pulse();
      test_reset_mid_stretch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
